// File: rtl/rom_share_arbiter.sv
// rom_share_arbiter: shares one synchronous ROM (one-cycle registered read) between
// two read ports. Each read takes IDLE -> ADDR -> DATA, and the ack is issued in the
// following IDLE cycle.
// Optional macro ROM_SHARE_ARBITER_FIXED_PRIO_EN: port A always wins contention.
// Without the macro, the port that was not granted last wins (round-robin).
module rom_share_arbiter #(
   parameter int unsigned ADDR_WIDTH = 12,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  a_req,
   input  logic [ADDR_WIDTH-1:0] a_addr,
   output logic                  a_ack,
   output logic [DATA_WIDTH-1:0] a_rdata,
   input  logic                  b_req,
   input  logic [ADDR_WIDTH-1:0] b_addr,
   output logic                  b_ack,
   output logic [DATA_WIDTH-1:0] b_rdata,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_dout,
   output logic                  busy
);

   typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

   localparam logic GrantA = 1'b0;
   localparam logic GrantB = 1'b1;

   state_e                r_state, w_state_nxt;
   logic                  r_grant, w_grant_nxt;
   logic                  r_last_grant, w_last_grant_nxt;
   logic [ADDR_WIDTH-1:0] r_rom_addr, w_rom_addr_nxt;
   logic [DATA_WIDTH-1:0] r_a_rdata, w_a_rdata_nxt;
   logic [DATA_WIDTH-1:0] r_b_rdata, w_b_rdata_nxt;
   logic                  r_a_ack, w_a_ack_nxt;
   logic                  r_b_ack, w_b_ack_nxt;
   logic                  w_pick_b;

   // Winner selection; only consulted in IDLE when at least one request is pending.
`ifdef ROM_SHARE_ARBITER_FIXED_PRIO_EN
   always_comb begin
      w_pick_b = b_req & ~a_req;
   end
`else
   always_comb begin
      w_pick_b = b_req & (~a_req | (r_last_grant == GrantA));
   end
`endif

   // Next-state and next-datapath values for the IDLE -> ADDR -> DATA sequence.
   always_comb begin
      w_state_nxt      = r_state;
      w_grant_nxt      = r_grant;
      w_last_grant_nxt = r_last_grant;
      w_rom_addr_nxt   = r_rom_addr;
      w_a_rdata_nxt    = r_a_rdata;
      w_b_rdata_nxt    = r_b_rdata;
      w_a_ack_nxt      = 1'b0;
      w_b_ack_nxt      = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (a_req || b_req) begin
               w_grant_nxt    = w_pick_b ? GrantB : GrantA;
               w_rom_addr_nxt = w_pick_b ? b_addr : a_addr;
               w_state_nxt    = StAddr;
            end
         end
         StAddr: begin
            // The ROM samples rom_addr on this edge; the data arrives one edge later.
            w_state_nxt = StData;
         end
         StData: begin
            if (r_grant == GrantB) begin
               w_b_rdata_nxt = rom_dout;
               w_b_ack_nxt   = 1'b1;
            end else begin
               w_a_rdata_nxt = rom_dout;
               w_a_ack_nxt   = 1'b1;
            end
            w_last_grant_nxt = r_grant;
            w_state_nxt      = StIdle;
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   // State and datapath registers with synchronous reset; last_grant=B lets A win first.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= StIdle;
         r_grant      <= GrantA;
         r_last_grant <= GrantB;
         r_rom_addr   <= '0;
         r_a_rdata    <= '0;
         r_b_rdata    <= '0;
         r_a_ack      <= 1'b0;
         r_b_ack      <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_grant      <= w_grant_nxt;
         r_last_grant <= w_last_grant_nxt;
         r_rom_addr   <= w_rom_addr_nxt;
         r_a_rdata    <= w_a_rdata_nxt;
         r_b_rdata    <= w_b_rdata_nxt;
         r_a_ack      <= w_a_ack_nxt;
         r_b_ack      <= w_b_ack_nxt;
      end
   end

   assign a_ack    = r_a_ack;
   assign b_ack    = r_b_ack;
   assign a_rdata  = r_a_rdata;
   assign b_rdata  = r_b_rdata;
   assign rom_addr = r_rom_addr;
   assign busy     = (r_state != StIdle);

endmodule

// File: tb/tb_rom_share_arbiter.sv
// Directed bench for rom_share_arbiter with a behavioural one-cycle-latency ROM.
module tb_rom_share_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        a_req, b_req;
   logic [11:0] a_addr, b_addr;
   logic        a_ack, b_ack;
   logic [7:0]  a_rdata, b_rdata;
   logic [11:0] rom_addr;
   logic [7:0]  rom_dout;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] rom [0:4095];

   rom_share_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .a_req   (a_req),
      .a_addr  (a_addr),
      .a_ack   (a_ack),
      .a_rdata (a_rdata),
      .b_req   (b_req),
      .b_addr  (b_addr),
      .b_ack   (b_ack),
      .b_rdata (b_rdata),
      .rom_addr(rom_addr),
      .rom_dout(rom_dout),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   // Synchronous ROM: data valid one clock after the address is presented.
   always @(posedge clk) rom_dout <= rom[rom_addr];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle_outputs(input string tag);
      check_eq({tag, "_a_ack"}, a_ack, 0);
      check_eq({tag, "_b_ack"}, b_ack, 0);
      check_eq({tag, "_a_rdata"}, a_rdata, 0);
      check_eq({tag, "_b_rdata"}, b_rdata, 0);
      check_eq({tag, "_rom_addr"}, rom_addr, 0);
      check_eq({tag, "_busy"}, busy, 0);
   endtask

   initial begin
      int nack;
      logic exp_b;
      logic [7:0] exp_d;
      logic [7:0] seq_d [4];

      for (int i = 0; i < 4096; i++) rom[i] = 8'hEE;
      rom[12'h000] = 8'hA9; rom[12'hFFF] = 8'h5C;
      rom[12'h100] = 8'h11; rom[12'h200] = 8'h22;
      rom[12'h010] = 8'h10; rom[12'h020] = 8'h20;
      rom[12'h001] = 8'hB1; rom[12'h002] = 8'hB2; rom[12'h003] = 8'hB3;
      seq_d[0] = 8'hA9; seq_d[1] = 8'hB1; seq_d[2] = 8'hB2; seq_d[3] = 8'hB3;

      rst = 1'b1; a_req = 1'b0; b_req = 1'b0; a_addr = '0; b_addr = '0;
      tick(); tick();
      check_idle_outputs("rst");
      rst = 1'b0;

      // Single port-A read of address 0x000.
      a_req = 1'b1; a_addr = 12'h000;
      tick();
      check_eq("t1_busy_addr", busy, 1);
      check_eq("t1_ack_early", a_ack, 0);
      tick();
      check_eq("t1_busy_data", busy, 1);
      tick();
      check_eq("t1_a_ack", a_ack, 1);
      check_eq("t1_a_rdata", a_rdata, 8'hA9);
      check_eq("t1_b_ack", b_ack, 0);
      check_eq("t1_busy_ack", busy, 0);
      a_req = 1'b0;
      tick();
      check_eq("t1_ack_pulse", a_ack, 0);
      check_eq("t1_rdata_hold", a_rdata, 8'hA9);

      // Single port-B read at the top address.
      b_req = 1'b1; b_addr = 12'hFFF;
      tick();
      check_eq("t2_rom_addr_addr", rom_addr, 12'hFFF);
      tick();
      check_eq("t2_rom_addr_data", rom_addr, 12'hFFF);
      tick();
      check_eq("t2_b_ack", b_ack, 1);
      check_eq("t2_b_rdata", b_rdata, 8'h5C);
      check_eq("t2_a_ack", a_ack, 0);
      check_eq("t2_a_rdata_kept", a_rdata, 8'hA9);
      b_req = 1'b0;
      tick();
      check_eq("t2_ack_pulse", b_ack, 0);

      // Both ports held for four transactions.
      a_req = 1'b1; a_addr = 12'h100; b_req = 1'b1; b_addr = 12'h200;
      nack = 0;
      for (int c = 1; c <= 20 && nack < 4; c++) begin
         tick();
         check_eq("t3_ack_excl", {31'd0, a_ack & b_ack}, 0);
         if (a_ack || b_ack) begin
`ifdef ROM_SHARE_ARBITER_FIXED_PRIO_EN
            exp_b = 1'b0;
`else
            exp_b = nack[0];
`endif
            exp_d = exp_b ? 8'h22 : 8'h11;
            check_eq("t3_port", b_ack, exp_b);
            check_eq("t3_cycle", c, 3 * (nack + 1));
            check_eq("t3_data", b_ack ? b_rdata : a_rdata, exp_d);
            nack++;
            if (nack == 4) begin
               a_req = 1'b0;
               b_req = 1'b0;
            end
         end
      end
      check_eq("t3_count", nack, 4);
      tick();
      check_eq("t3_idle", busy, 0);

      // Address change after grant must not affect the read.
      a_req = 1'b1; a_addr = 12'h010;
      tick();
      a_addr = 12'h020;
      tick();
      check_eq("t4_rom_addr", rom_addr, 12'h010);
      tick();
      check_eq("t4_a_ack", a_ack, 1);
      check_eq("t4_a_rdata", a_rdata, 8'h10);
      a_req = 1'b0;
      tick();

      // Reset during DATA aborts without an ack; a new read then completes.
      a_req = 1'b1; a_addr = 12'h020;
      tick(); tick();
      check_eq("t5_in_data", busy, 1);
      rst = 1'b1;
      tick();
      check_idle_outputs("t5_rst");
      rst = 1'b0;
      nack = 0;
      for (int c = 1; c <= 10 && nack == 0; c++) begin
         tick();
         if (a_ack) begin
            check_eq("t5_cycle", c, 3);
            check_eq("t5_a_rdata", a_rdata, 8'h20);
            nack++;
            a_req = 1'b0;
         end
      end
      check_eq("t5_count", nack, 1);
      tick();

      // Back-to-back port-A reads with request held and address stepped at each ack.
      a_req = 1'b1; a_addr = 12'h000;
      nack = 0;
      for (int c = 1; c <= 20 && nack < 4; c++) begin
         tick();
         check_eq("t6_busy", busy, {31'd0, ~a_ack});
         if (a_ack) begin
            check_eq("t6_cycle", c, 3 * (nack + 1));
            check_eq("t6_data", a_rdata, seq_d[nack]);
            nack++;
            a_addr = 12'(nack);
            if (nack == 4) a_req = 1'b0;
         end
      end
      check_eq("t6_count", nack, 4);
      tick();
      check_eq("t6_idle", busy, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rom_share_arbiter.md
Name: rom_share_arbiter

Overview:
- Shares one synchronous 4 KiB ROM (12-bit address, 8-bit data, one-cycle registered read) between two requesters: port A (CPU bus side) and port B (secondary reader, e.g. a ROM-to-RAM loader or debug reader).
- Arbitrates with a round-robin policy and drives the single ROM address bus.
- Captures the ROM data and returns it with a one-cycle ack pulse per completed read.
- Sits between the requesters and the ROM wrapper in the Apple One top level.

Parameters:
ADDR_WIDTH, 12, ROM address width; ROM depth is 2**ADDR_WIDTH.
DATA_WIDTH, 8, ROM data width.

Ports:
clk  input  1  system clock; all logic on posedge.
rst  input  1  synchronous, active-high reset.
a_req  input  1  port A read request; held high until a_ack.
a_addr  input  ADDR_WIDTH  port A read address; stable while a_req is high.
a_ack  output  1  one-cycle pulse: a_rdata is valid.
a_rdata  output  DATA_WIDTH  port A read data; held until the next a_ack.
b_req  input  1  port B read request; same rules as port A.
b_addr  input  ADDR_WIDTH  port B read address.
b_ack  output  1  one-cycle pulse: b_rdata is valid.
b_rdata  output  DATA_WIDTH  port B read data; held until the next b_ack.
rom_addr  output  ADDR_WIDTH  registered address to the ROM.
rom_dout  input  DATA_WIDTH  ROM data; valid one clock after rom_addr is presented.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values: state=IDLE; a_ack=b_ack=0; a_rdata=b_rdata=0; rom_addr=0; busy=0; grant=A; last_grant=B, so port A wins the first contention.
- State machine: IDLE -> ADDR -> DATA -> IDLE.
- IDLE:
  - No request pending: stay in IDLE.
  - At least one request pending at edge E0: pick a winner, set grant, register rom_addr from the winner's address, go to ADDR.
- ADDR: the ROM samples rom_addr at edge E1. Go to DATA unconditionally.
- DATA:
  - At edge E2, capture rom_dout into the granted port's rdata register.
  - Pulse that port's ack for exactly the cycle following E2.
  - Set last_grant=grant and return to IDLE.
- Latency: ack is high in the third cycle after the request is first sampled at E0.
- Throughput: at most one read per 3 cycles.
- The ack cycle is an IDLE cycle. A request still high during its own ack cycle is sampled at the next edge as a new request. Requesters must drop req in the ack cycle if no further read is wanted.
- Arbitration:
  - Only one port requesting: that port wins.
  - Both ports requesting: the port != last_grant wins (round-robin).
- The losing request stays pending and is served in the next transaction.
- Under continuous requests from both ports, grants strictly alternate A, B, A, B.
- Address handling: rom_addr is held constant from ADDR through DATA. Changes to the requester's addr after E0 have no effect on the current read.
- Withdrawn request: if the granted port drops req mid-transaction, the read still completes and the ack is still issued. Requesters must not do this.
- The non-granted port's ack and rdata are unchanged during a transaction.
- a_ack and b_ack are never high in the same cycle.
- busy is high during ADDR and DATA only; busy=0 in the ack cycle.
- Reset mid-transaction:
  - Aborts the transaction with no ack.
  - All outputs return to reset values at the next edge.
  - The first transaction after reset follows normal arbitration.
- Address width: no arithmetic is performed on addresses; the full ADDR_WIDTH passes through, including the maximum address 0xFFF.

Optional Feature:
- Macro: ROM_SHARE_ARBITER_FIXED_PRIO_EN.
- When defined:
  - Port A always wins simultaneous requests; last_grant is not used for arbitration.
  - Port B can starve under continuous port A requests.
  - Latency and handshake are unchanged.
- When undefined: round-robin as described in Behaviour.

Test Plan:
- Reset, then a_req=1, a_addr=0x000, with rom[0x000]=0xA9 -> a_ack pulses in the 3rd cycle after sampling; a_rdata=0xA9; b_ack stays 0.
- b_req only, b_addr=0xFFF, rom[0xFFF]=0x5C -> b_rdata=0x5C, b_ack is a single-cycle pulse, rom_addr=0xFFF during ADDR and DATA.
- a_req and b_req raised together and held for 4 transactions, addresses 0x100 and 0x200 -> ack order A, B, A, B, each 3 cycles apart. With ROM_SHARE_ARBITER_FIXED_PRIO_EN defined -> A, A, A, A.
- Port A granted on 0x010; a_addr changed to 0x020 during ADDR -> a_rdata=rom[0x010].
- rst asserted during DATA of a port A read -> no a_ack; all outputs are 0 the cycle after rst; a new a_req completes normally afterwards.
- Back-to-back port A reads with req held continuously and a_addr stepped 0x000..0x003 at each ack -> four acks exactly 3 cycles apart with matching data; busy=0 only in the ack cycles.
